// File: rtl/host_if_pkg.sv
// Shared types and byte-lane helpers for the layer-controller memory responder.
// Lines are 16 bytes wide; byte k of a 128b word lives in bits [8k+7:8k].
package host_if_pkg;

  localparam int LINE_BYTES = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACC0,
    ACC1,
    FIN,
    DONE
  } state_e;

  // Byte count is len+1, so len=0 enables one lane and len=15 enables all sixteen.
  function automatic logic [LINE_BYTES-1:0] len_to_mask(input logic [3:0] len);
    return 16'hFFFF >> (4'd15 - len);
  endfunction

  function automatic logic [127:0] rotl_bytes(input logic [127:0] d, input logic [3:0] n);
    logic [255:0] t;
    t = {d, d} << {n, 3'b000};
    return t[255:128];
  endfunction

  function automatic logic [127:0] rotr_bytes(input logic [127:0] d, input logic [3:0] n);
    logic [255:0] t;
    t = {d, d} >> {n, 3'b000};
    return t[127:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index requester at or after the pointer.
// The pointer advances only when the owner reports a completed grant via i_upd.
module rr_arbiter #(
  parameter int NPORTS = 8,
  parameter int IW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NPORTS-1:0] i_req,
  input  logic              i_upd,
  input  logic [IW-1:0]     i_upd_idx,
  output logic [NPORTS-1:0] o_gnt,
  output logic [IW-1:0]     o_gnt_idx,
  output logic              o_valid
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;

  function automatic logic [IW-1:0] wrap_idx(input int k);
    if (k >= NPORTS) return IW'(k - NPORTS);
    return IW'(k);
  endfunction

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_valid   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NPORTS; i++) begin
      w_idx = wrap_idx(int'(r_ptr) + i);
      if (!o_valid && i_req[w_idx]) begin
        o_valid        = 1'b1;
        o_gnt[w_idx]   = 1'b1;
        o_gnt_idx      = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_upd) begin
      r_ptr <= (i_upd_idx == IW'(NPORTS - 1)) ? '0 : i_upd_idx + IW'(1);
    end
  end

endmodule

// File: rtl/layer_mem_responder.sv
// Services one layer-controller memory request at a time against a 128b-line SRAM.
// Build option: UNALIGNED_SPLIT_EN lets a line-crossing request spill into line+1.
module layer_mem_responder
  import host_if_pkg::*;
#(
  parameter int NPORTS = 8,
  parameter int DW     = 128,
  parameter int AW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    req_we,
  input  logic [NPORTS-1:0]    req_re,
  input  logic [NPORTS*AW-1:0] req_addr,
  input  logic [NPORTS*4-1:0]  req_len,
  input  logic [NPORTS*DW-1:0] req_wdata,
  output logic [NPORTS-1:0]    rsp_done,
  output logic [DW-1:0]        rsp_rdata,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-5:0]        mem_addr,
  output logic [15:0]          mem_be,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int LW = AW - 4;
`ifdef UNALIGNED_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  state_e            r_state, w_state_nxt;
  logic [NPORTS-1:0] w_arb_req, w_gnt_oh, r_gnt_oh, r_excl;
  logic [IW-1:0]     w_gnt_idx, r_gidx;
  logic              w_gnt_valid;

  logic              w_sel_we;
  logic [AW-1:0]     w_sel_addr;
  logic [3:0]        w_sel_len;
  logic [DW-1:0]     w_sel_wdata;

  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [3:0]        r_len;
  logic [DW-1:0]     r_wdata, r_beat0, r_rdata;

  logic [3:0]        w_off;
  logic              w_split;
  logic [15:0]       w_mask;
  logic [31:0]       w_be32;
  logic [LW-1:0]     w_line0, w_line1;
  logic [DW-1:0]     w_wdata_rot, w_rot_cur, w_rot_b0, w_rd_data;

  // A port that just finished may still hold its request for one cycle; mask it out.
  assign w_arb_req = (req_we | req_re) & ~r_excl;

  rr_arbiter #(
    .NPORTS (NPORTS),
    .IW     (IW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_arb_req),
    .i_upd     (r_state == DONE),
    .i_upd_idx (r_gidx),
    .o_gnt     (w_gnt_oh),
    .o_gnt_idx (w_gnt_idx),
    .o_valid   (w_gnt_valid)
  );

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_wdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (w_gnt_idx == IW'(p)) begin
        w_sel_we    = req_we[p];
        w_sel_addr  = req_addr[p*AW +: AW];
        w_sel_len   = req_len[p*4 +: 4];
        w_sel_wdata = req_wdata[p*DW +: DW];
      end
    end
  end

  assign w_off       = r_addr[3:0];
  assign w_split     = SPLIT_EN && (({1'b0, w_off} + {1'b0, r_len}) > 5'd15);
  assign w_mask      = len_to_mask(r_len);
  assign w_be32      = {16'b0, w_mask} << w_off;
  assign w_line0     = r_addr[AW-1:4];
  assign w_line1     = w_line0 + LW'(1);
  assign w_wdata_rot = rotl_bytes(r_wdata, w_off);

  // Request byte k sits at lane off+k; lanes past 15 came from the second beat.
  always_comb begin
    w_rot_cur = rotr_bytes(mem_rdata, w_off);
    w_rot_b0  = rotr_bytes(r_beat0, w_off);
    w_rd_data = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      if (w_mask[k]) begin
        w_rd_data[k*8 +: 8] = (!w_split || (({1'b0, w_off} + 5'(k)) > 5'd15))
                              ? w_rot_cur[k*8 +: 8] : w_rot_b0[k*8 +: 8];
      end
    end
  end

  // NOTE: every output and next-state term gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_be      = '0;
    mem_wdata   = '0;
    rsp_done    = '0;
    rsp_rdata   = '0;
    case (r_state)
      IDLE: if (w_gnt_valid) w_state_nxt = ACC0;
      ACC0: begin
        mem_en   = 1'b1;
        mem_we   = r_we;
        mem_addr = w_line0;
        if (r_we) begin
          mem_be    = w_split ? w_be32[15:0] : (w_be32[15:0] | w_be32[31:16]);
          mem_wdata = w_wdata_rot;
        end
        w_state_nxt = w_split ? ACC1 : FIN;
      end
      ACC1: begin
        mem_en   = 1'b1;
        mem_we   = r_we;
        mem_addr = w_line1;
        if (r_we) begin
          mem_be    = w_be32[31:16];
          mem_wdata = w_wdata_rot;
        end
        w_state_nxt = FIN;
      end
      FIN:  w_state_nxt = DONE;
      DONE: begin
        rsp_done    = r_gnt_oh;
        rsp_rdata   = r_rdata;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt_oh <= '0;
      r_gidx   <= '0;
      r_excl   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_excl  <= (r_state == DONE) ? r_gnt_oh : '0;
      if (r_state == IDLE && w_gnt_valid) begin
        r_gnt_oh <= w_gnt_oh;
        r_gidx   <= w_gnt_idx;
      end
    end
  end

  // NOTE: the request/data capture registers carry no reset; every use is gated by the state.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_gnt_valid) begin
      r_we    <= w_sel_we;
      r_addr  <= w_sel_addr;
      r_len   <= w_sel_len;
      r_wdata <= w_sel_wdata;
    end
    if (r_state == ACC1) r_beat0 <= mem_rdata;
    if (r_state == FIN)  r_rdata <= r_we ? '0 : w_rd_data;
  end

endmodule
